// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// Module : fetch_stage_pkg
// Brief  : Shared definitions for the fetch stage and its consumers.
//          - fetch_state_t : fetch sequencer state encodings (2 bits)
//          - NOP_INSTR     : canonical bubble instruction (addi x0,x0,0);
//                            decode also uses this value for its own bubbles
//          - PC_STEP       : byte distance between sequential instructions
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,   // one dead cycle after reset before the first request
    FS_FETCH = 2'd1,   // request outstanding at pc
    FS_HOLD  = 2'd2,   // response parked in the hold buffer, waiting on stall
    FS_DRAIN = 2'd3    // squashed request still in flight, response discarded
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
// ============================================================================
// Module : if_id_reg
// Brief  : IF/ID pipeline register holding {pc, instr, valid}.
//          squash has priority over load and turns the slot into a NOP
//          bubble; the pc field is left untouched by a squash because
//          nothing downstream looks at it while valid is low.
// Ports  : clk, rst        clock / synchronous active-high reset
//          load            capture pc_in/instr_in as a valid instruction
//          squash          invalidate the slot (instr forced to NOP)
//          pc_in, instr_in payload to capture
//          pc, instr, valid registered IF/ID contents
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            squash,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (squash) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// Brief  : PC register, instruction-memory fetch sequencer and IF/ID
//          register. Accepts stall (pc_write/if_id_write) from the hazard
//          unit and flush/redirect from EX; delivers {pc, instr, valid}
//          to decode. Sustains one instruction per cycle with a
//          zero-latency instruction memory.
// Params : XLEN      address/PC width
//          RESET_PC  PC after reset (low two bits must be zero)
// Ports  : clk, rst          clock / synchronous active-high reset
//          pc_write          1 = PC may advance
//          if_id_write       1 = IF/ID may load
//          flush             squash IF/ID and redirect to redirect_pc
//          redirect_pc       redirect target (low two bits ignored)
//          imem_req          fetch request valid (decoded from state)
//          imem_addr         fetch address, stable until imem_rvalid
//          imem_rdata        instruction word, valid with imem_rvalid
//          imem_rvalid       response strobe, may coincide with request
//          if_id_pc          PC of the instruction in IF/ID
//          if_id_instr       instruction in IF/ID (NOP when invalid)
//          if_id_valid       IF/ID holds a real instruction
//          stall_cycles      (FETCH_PERF_CNT_EN) cycles a valid IF/ID
//                            instruction was held by a stall, saturating
//          flush_count       (FETCH_PERF_CNT_EN) flushes seen, saturating
// Config : define FETCH_PERF_CNT_EN to add the two performance counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_rvalid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
`endif
);

  localparam logic [XLEN-1:0] PC_INC     = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  // Address of a squashed request still awaiting its response; imem_addr
  // must stay on it until the response arrives even though pc has already
  // moved to the redirect target.
  logic [XLEN-1:0] drain_addr, drain_addr_nxt;
  // Hold buffer: a response that arrived while IF/ID was stalled.
  logic [XLEN-1:0] hold_pc, hold_pc_nxt;
  logic [31:0]     hold_instr, hold_instr_nxt;

  logic            advance;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] redirect_aligned;

  logic            ifid_load;
  logic            ifid_squash;
  logic [XLEN-1:0] ifid_pc_in;
  logic [31:0]     ifid_instr_in;

  assign advance          = pc_write & if_id_write;
  assign pc_plus          = pc + PC_INC;          // wraps modulo 2^XLEN
  assign redirect_aligned = redirect_pc & ALIGN_MASK;

  // --------------------------------------------------------------------------
  // State register, PC, drain address and hold buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FS_IDLE;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drain_addr <= drain_addr_nxt;
      hold_pc    <= hold_pc_nxt;
      hold_instr <= hold_instr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, request decode and IF/ID control
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drain_addr_nxt = drain_addr;
    hold_pc_nxt    = hold_pc;
    hold_instr_nxt = hold_instr;
    ifid_load      = 1'b0;
    ifid_squash    = 1'b0;
    ifid_pc_in     = pc;
    ifid_instr_in  = imem_rdata;
    imem_req       = 1'b0;
    imem_addr      = pc;

    case (state)
      FS_IDLE: begin
        // Responses left over from before reset land here and are ignored.
        state_nxt = FS_FETCH;
      end

      FS_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid && advance) begin
          ifid_load = 1'b1;
          pc_nxt    = pc_plus;
        end else if (imem_rvalid) begin
          // Decode is stalled: park the word so the request can retire.
          hold_pc_nxt    = pc;
          hold_instr_nxt = imem_rdata;
          state_nxt      = FS_HOLD;
        end else if (advance) begin
          ifid_squash = 1'b1;               // bubble while memory is slow
        end
      end

      FS_HOLD: begin
        if (advance) begin
          ifid_load      = 1'b1;
          ifid_pc_in     = hold_pc;
          ifid_instr_in  = hold_instr;
          pc_nxt         = pc_plus;
          hold_pc_nxt    = '0;
          hold_instr_nxt = NOP_INSTR;
          state_nxt      = FS_FETCH;
        end
      end

      FS_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
        if (imem_rvalid) begin
          state_nxt = FS_FETCH;             // stale word is dropped
        end
      end

      default: begin
        state_nxt = FS_IDLE;
      end
    endcase

    // Flush overrides everything above, including a stall.
    if (flush) begin
      ifid_load      = 1'b0;
      ifid_squash    = 1'b1;
      hold_pc_nxt    = '0;
      hold_instr_nxt = NOP_INSTR;
      pc_nxt         = redirect_aligned;
      if ((state == FS_FETCH || state == FS_DRAIN) && !imem_rvalid) begin
        // A request is still in flight; its response must be absorbed
        // before a new address can be issued.
        state_nxt = FS_DRAIN;
        if (state == FS_FETCH) begin
          drain_addr_nxt = pc;
        end
      end else begin
        state_nxt = FS_FETCH;
      end
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID pipeline register
  // --------------------------------------------------------------------------
  if_id_reg #(
    .XLEN (XLEN)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .squash   (ifid_squash),
    .pc_in    (ifid_pc_in),
    .instr_in (ifid_instr_in),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (if_id_valid && !advance && !flush && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Self-checking bench for fetch_stage. A transaction-level model
//          tracks what IF/ID and the fetch request must be every cycle;
//          directed scenarios pin the model with literal expectations,
//          then randomized stall/flush/reset/latency traffic follows.
//          Build with FETCH_PERF_CNT_EN to also check the counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int S_VALID = 0, S_INSTR = 1, S_IFPC = 2, S_REQ = 3, S_ADDR = 4,
                 S_ADDR2 = 5, S_IFPC2 = 6, S_STALL = 7, S_FCNT = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pc_write, if_id_write, flush;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_pc, if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, sc2, fc2;
`endif

  // Second instance: reset PC at the top of memory, free-running with a
  // zero-latency memory, to observe PC wrap-around.
  logic        req2, valid2;
  logic [31:0] addr2, pc2, instr2;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
    .flush(flush), .redirect_pc(redirect_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .pc_write(1'b1), .if_id_write(1'b1),
    .flush(1'b0), .redirect_pc(32'h0), .imem_req(req2),
    .imem_addr(addr2), .imem_rdata(~addr2), .imem_rvalid(req2),
    .if_id_pc(pc2), .if_id_instr(instr2), .if_id_valid(valid2)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(sc2), .flush_count(fc2)
`endif
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  // ---------------- behavioural model ----------------
  // The fetch unit is either starting up, has an instruction parked,
  // is waiting out a squashed request, or is simply fetching at m_pc.
  logic        m_starting, m_parked, m_squashed_inflight;
  logic [31:0] m_pc, m_stale_addr, m_park_pc, m_park_instr;
  logic        m_ifv;
  logic [31:0] m_ifpc, m_ifinstr, m_stall, m_fcnt;

  function automatic logic exp_req();
    return !m_starting && !m_parked;
  endfunction
  function automatic logic [31:0] exp_addr();
    return m_squashed_inflight ? m_stale_addr : m_pc;
  endfunction

  task automatic model_step();
    logic adv, rv, plain_fetch;
    adv = pc_write & if_id_write;
    rv  = imem_rvalid;
    if (rst) begin
      m_starting = 1; m_parked = 0; m_squashed_inflight = 0;
      m_pc = 32'h0; m_ifv = 0; m_ifpc = 32'h0; m_ifinstr = NOP_INSTR;
      m_stall = 0; m_fcnt = 0;
      return;
    end
    if (m_ifv && !adv && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
    plain_fetch = !m_starting && !m_parked && !m_squashed_inflight;
    if (flush) begin
      m_ifv = 0; m_ifinstr = NOP_INSTR; m_parked = 0; m_starting = 0;
      if (plain_fetch && !rv) begin
        m_squashed_inflight = 1; m_stale_addr = m_pc;
      end else if (!(m_squashed_inflight && !rv)) begin
        m_squashed_inflight = 0;
      end
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (m_starting) begin
      m_starting = 0;
    end else if (m_squashed_inflight) begin
      if (rv) m_squashed_inflight = 0;
    end else if (m_parked) begin
      if (adv) begin
        m_ifv = 1; m_ifpc = m_park_pc; m_ifinstr = m_park_instr;
        m_pc = m_pc + 4; m_parked = 0;
      end
    end else if (rv && adv) begin
      m_ifv = 1; m_ifpc = m_pc; m_ifinstr = imem_rdata; m_pc = m_pc + 4;
    end else if (rv) begin
      m_parked = 1; m_park_pc = m_pc; m_park_instr = imem_rdata;
    end else if (adv) begin
      m_ifv = 0; m_ifinstr = NOP_INSTR;
    end
  endtask

  // ---------------- memory responder ----------------
  int lat  = 0;
  int wcnt = 0;

  // ---------------- checking ----------------
  typedef struct { string name; int sel; logic [31:0] exp; } lit_t;
  lit_t lit_q[$];
  int   n_chk = 0, n_fail = 0;
  logic chk_en = 1'b0;

  function automatic logic [31:0] sig_val(input int s);
    case (s)
      S_VALID: return {31'b0, if_id_valid};
      S_INSTR: return if_id_instr;
      S_IFPC:  return if_id_pc;
      S_REQ:   return {31'b0, imem_req};
      S_ADDR:  return imem_addr;
      S_ADDR2: return addr2;
      S_IFPC2: return pc2;
`ifdef FETCH_PERF_CNT_EN
      S_STALL: return stall_cycles;
      S_FCNT:  return flush_count;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ifv});
      chk("if_id_instr", if_id_instr, m_ifinstr);
      if (m_ifv) chk("if_id_pc", if_id_pc, m_ifpc);
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
      if (exp_req()) chk("imem_addr", imem_addr, exp_addr());
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, m_stall);
      chk("flush_count", flush_count, m_fcnt);
`endif
    end
    while (lit_q.size() > 0) begin
      lit_t e;
      e = lit_q.pop_front();
      chk(e.name, sig_val(e.sel), e.exp);
    end
  end

  task automatic lit(input string name, input int sel, input logic [31:0] exp);
    lit_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    lit_q.push_back(e);
  endtask

  // One clock cycle: apply inputs, answer the request, then advance the
  // model and the responder past the coming clock edge.
  task automatic step(input logic r, input logic pw, input logic iw,
                      input logic f, input logic [31:0] rp);
    @(posedge clk); #1;
    rst = r; pc_write = pw; if_id_write = iw; flush = f; redirect_pc = rp;
    #1;
    imem_rvalid = imem_req && (wcnt >= lat);
    imem_rdata  = data_of(imem_addr);
    @(negedge clk); #1;
    model_step();
    if (rst || !imem_req || imem_rvalid) wcnt = 0;
    else wcnt = wcnt + 1;
  endtask

  initial begin
    rst = 1; pc_write = 1; if_id_write = 1; flush = 0; redirect_pc = 0;
    imem_rvalid = 0; imem_rdata = 0;

    step(1, 1, 1, 0, 0);
    chk_en = 1;

    // reset state / IDLE cycle
    lit("rst_valid", S_VALID, 32'h0);
    lit("rst_instr", S_INSTR, NOP_INSTR);
    lit("rst_ifpc",  S_IFPC,  32'h0);
    lit("idle_req",  S_REQ,   32'h0);
    step(0, 1, 1, 0, 0);
    // zero-latency streaming
    lit("c1_req",  S_REQ,   32'h1);
    lit("c1_addr", S_ADDR,  32'h0);
    lit("wrap_a0", S_ADDR2, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 0);
    lit("c2_addr",  S_ADDR,  32'h4);
    lit("c2_valid", S_VALID, 32'h1);
    lit("c2_ifpc",  S_IFPC,  32'h0);
    lit("c2_instr", S_INSTR, 32'h1234_5677);
    lit("wrap_a1",  S_ADDR2, 32'h0);
    lit("wrap_pc",  S_IFPC2, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 0);
    // stall three cycles once 0x8 has been fetched
    lit("c3_addr", S_ADDR, 32'h8);
    lit("c3_ifpc", S_IFPC, 32'h4);
    step(0, 0, 1, 0, 0);
    lit("hold_req",  S_REQ,  32'h0);
    lit("hold_ifpc", S_IFPC, 32'h4);
    step(0, 1, 0, 0, 0);
    lit("hold_req2", S_REQ, 32'h0);
    step(0, 0, 0, 0, 0);
    lit("rel_req", S_REQ, 32'h0);
    step(0, 1, 1, 0, 0);
    // release: IF/ID gets 0x8, fetch resumes at 0xC; flush under stall
    lit("rel_ifpc", S_IFPC, 32'h8);
    lit("rel_addr", S_ADDR, 32'hC);
    step(0, 0, 0, 1, 32'h103);
    // flushed slot, redirect to 0x100; memory becomes 3-cycle latency
    lat = 3;
    lit("fl_valid", S_VALID, 32'h0);
    lit("fl_instr", S_INSTR, NOP_INSTR);
    lit("fl_addr",  S_ADDR,  32'h100);
    step(0, 1, 1, 0, 0);
    lit("w1_addr", S_ADDR, 32'h100);
    step(0, 1, 1, 1, 32'h200);
    lit("drain_req",  S_REQ,  32'h1);
    lit("drain_addr", S_ADDR, 32'h100);
    step(0, 1, 1, 0, 0);
    lit("drain_addr2", S_ADDR, 32'h100);
    step(0, 1, 1, 0, 0);
    lit("redir_addr",  S_ADDR,  32'h200);
    lit("redir_valid", S_VALID, 32'h0);
    step(0, 1, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, pw, iw, f;
      logic [31:0] rp;
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(0, 3);
      r  = ($urandom_range(0, 199) == 0);
      pw = ($urandom_range(0, 3) != 0);
      iw = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 11) == 0);
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom);
      step(r, pw, iw, f, rp);
    end

`ifdef FETCH_PERF_CNT_EN
    // 5 stall cycles with a valid IF/ID, then 2 flushes
    lat = 0;
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 32'h40);
    step(0, 1, 1, 1, 32'h80);
    lit("perf_stall", S_STALL, 32'd5);
    lit("perf_flush", S_FCNT,  32'd2);
    step(0, 1, 1, 0, 0);
`endif

    step(0, 1, 1, 0, 0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
